// File: rtl/dma_pkg.sv
// Shared DMA types: FSM states, element width encoding and the OBI request/response
// structs used by the DMA manager and the DMA register block.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_FINISH
    } dma_state_e;

    typedef enum logic {
        ELEM_BYTE = 1'b0,
        ELEM_WORD = 1'b1
    } elem_width_e;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned data_width;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{addr_width: 32, data_width: 32};

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aid;
        logic        a_optional;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    function automatic logic [3:0] elem_be(elem_width_e w, logic [1:0] lane);
        return (w == ELEM_WORD) ? 4'b1111 : (4'b0001 << lane);
    endfunction

    function automatic logic [31:0] elem_addr(elem_width_e w, logic [31:0] a);
        return (w == ELEM_WORD) ? {a[31:2], 2'b00} : a;
    endfunction

endpackage

// File: rtl/dma_obi_mgr.sv
// DMA manager: copies a strided run of byte or word elements from src to dst
// over a single OBI manager port, keeping at most one transaction in flight.
module dma_obi_mgr
    import dma_pkg::*;
#(
    parameter obi_cfg_t ObiCfg = ObiDefaultConfig,
    parameter type mgr_obi_req_t = obi_req_t,
    parameter type mgr_obi_rsp_t = obi_rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [31:0]  src_addr_i,
    input  logic [31:0]  dst_addr_i,
    input  logic [7:0]   offset_i,
    input  logic [10:0]  repeat_i,
    input  logic         word_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [10:0]  remaining_o,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i
);

    // state      | meaning
    // IDLE       | waiting for start_i
    // RD_REQ     | read request on the bus, waiting for gnt
    // RD_WAIT    | read granted, waiting for rvalid
    // WR_REQ     | write request on the bus, waiting for gnt
    // WR_WAIT    | write granted, waiting for rvalid
    // FINISH     | transfer over, done pulse follows

    localparam logic [31:0] AddrMask = (ObiCfg.addr_width >= 32) ? 32'hFFFF_FFFF :
                                       32'((64'd1 << ObiCfg.addr_width) - 64'd1);

    dma_state_e   state_q, state_d;
    logic [31:0]  src_q, src_d, dst_q, dst_d;
    logic [7:0]   offset_q, offset_d;
    logic [10:0]  rem_q, rem_d;
    elem_width_e  width_q, width_d;
    logic         err_q, err_d;
    logic         done_q, err_pulse_q;
    mgr_obi_req_t req_q, req_d;

    logic [31:0]  src_inc, dst_inc;
    logic [10:0]  rem_dec;
    logic [7:0]   rd_byte;

    assign src_inc = (src_q + {24'b0, offset_q}) & AddrMask;
    assign dst_inc = (dst_q + {24'b0, offset_q}) & AddrMask;
    assign rem_dec = rem_q - 11'd1;
    assign rd_byte = mgr_rsp_i.rdata[{src_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d          = state_q;
        src_d            = src_q;
        dst_d            = dst_q;
        offset_d         = offset_q;
        rem_d            = rem_q;
        width_d          = width_q;
        err_d            = err_q;
        req_d            = req_q;
        req_d.aid        = 1'b0;
        req_d.a_optional = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rem_d = repeat_i;
                    err_d = 1'b0;
                    if (repeat_i == 11'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        src_d       = src_addr_i;
                        dst_d       = dst_addr_i;
                        offset_d    = offset_i;
                        width_d     = elem_width_e'(word_i);
                        state_d     = ST_RD_REQ;
                        req_d.req   = 1'b1;
                        req_d.we    = 1'b0;
                        req_d.addr  = elem_addr(elem_width_e'(word_i), src_addr_i);
                        req_d.be    = elem_be(elem_width_e'(word_i), src_addr_i[1:0]);
                        req_d.wdata = '0;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mgr_rsp_i.gnt) begin
                    state_d   = ST_RD_WAIT;
                    req_d.req = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (mgr_rsp_i.rvalid) begin
                    if (mgr_rsp_i.err) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_WR_REQ;
                        req_d.req   = 1'b1;
                        req_d.we    = 1'b1;
                        req_d.addr  = elem_addr(width_q, dst_q);
                        req_d.be    = elem_be(width_q, dst_q[1:0]);
                        // byte writes land on every lane so the slave picks the one be selects
                        req_d.wdata = (width_q == ELEM_WORD) ? mgr_rsp_i.rdata : {4{rd_byte}};
                    end
                end
            end
            ST_WR_REQ: begin
                if (mgr_rsp_i.gnt) begin
                    state_d   = ST_WR_WAIT;
                    req_d.req = 1'b0;
                end
            end
            ST_WR_WAIT: begin
                if (mgr_rsp_i.rvalid) begin
                    if (mgr_rsp_i.err) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                    end else begin
                        rem_d = rem_dec;
                        src_d = src_inc;
                        dst_d = dst_inc;
                        if (rem_dec == 11'd0 || abort_i) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d    = ST_RD_REQ;
                            req_d.req  = 1'b1;
                            req_d.we   = 1'b0;
                            req_d.addr = elem_addr(width_q, src_inc);
                            req_d.be   = elem_be(width_q, src_inc[1:0]);
                        end
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            offset_q    <= '0;
            rem_q       <= '0;
            width_q     <= ELEM_BYTE;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            offset_q    <= offset_d;
            rem_q       <= rem_d;
            width_q     <= width_d;
            err_q       <= err_d;
            done_q      <= (state_q == ST_FINISH);
            err_pulse_q <= (state_q == ST_FINISH) && err_q;
            req_q       <= req_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_pulse_q;
    assign remaining_o = rem_q;
    assign mgr_req_o   = req_q;

endmodule
